// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD message writer and its character ROM.
// The default message image is a printable-ASCII ramp addressed by flat ROM index.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SET_LINE,
      FETCH,
      WRITE_CHR,
      GAP,
      FINISH
   } state_t;

   localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
   localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;
   localparam logic [7:0] LINE2_OFFSET  = 8'h40;

   function automatic logic [7:0] rom_byte(input int unsigned idx);
      return 8'(32 + (idx % 95));
   endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Message character store: DEPTH bytes, registered read with one cycle of latency.
module lcd_msg_rom
   import lcd_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic          clk,
   input  logic [AW-1:0] addr,
   output logic [7:0]    q
);

   always_ff @(posedge clk) begin
      q <= rom_byte(32'(addr));
   end

endmodule

// File: rtl/lcd_msg_writer.sv
// Writes a stored message to an Avalon-MM character LCD: clear, then per line a
// DDRAM address command followed by MSG_LEN characters, with a one-cycle gap between writes.
module lcd_msg_writer
   import lcd_pkg::*;
#(
   parameter int NUM_MSG = 4,
   parameter int LINES   = 2,
   parameter int MSG_LEN = 16,
   parameter int TIMEOUT = 1024
)(
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          start,
   input  logic [((NUM_MSG > 1) ? $clog2(NUM_MSG) : 1)-1:0] msg_sel,
   output logic                                          busy,
   output logic                                          done,
   output logic                                          error,
   output logic                                          address,
   output logic                                          chipselect,
   output logic                                          write,
   output logic [7:0]                                    writedata,
   input  logic                                          waitrequest
);

   localparam int SEL_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
   localparam int LM    = LINES * MSG_LEN;
   localparam int DEPTH = NUM_MSG * LM;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int CW    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int PW    = (LM > 1) ? $clog2(LM) : 1;
   localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [SEL_W-1:0] MAX_MSG   = SEL_W'(NUM_MSG - 1);
   localparam logic [LW-1:0]    LAST_LINE = LW'(LINES - 1);
   localparam logic [CW-1:0]    LAST_COL  = CW'(MSG_LEN - 1);
   localparam logic [PW-1:0]    LAST_POS  = PW'(LM - 1);
   localparam logic [TW-1:0]    LAST_WAIT = TW'(TIMEOUT - 1);

   state_t           state;
   logic [SEL_W-1:0] msg;
   logic [LW-1:0]    line;
   logic [CW-1:0]    col;
   logic [PW-1:0]    pos;
   logic [TW-1:0]    tcnt;
   logic [AW-1:0]    rom_addr;
   logic [7:0]       rom_q;

   // pos always points at the next character to send, so the ROM word is
   // already settled by the time FETCH loads it into writedata.
   assign rom_addr = AW'(msg) * AW'(LM) + AW'(pos);

   lcd_msg_rom #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_rom (
      .clk  (clk),
      .addr (rom_addr),
      .q    (rom_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         chipselect <= 1'b0;
         write      <= 1'b0;
         address    <= 1'b0;
         writedata  <= 8'h00;
         msg        <= '0;
         line       <= '0;
         col        <= '0;
         pos        <= '0;
         tcnt       <= '0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  msg        <= (msg_sel > MAX_MSG) ? MAX_MSG : msg_sel;
                  busy       <= 1'b1;
                  line       <= '0;
                  col        <= '0;
                  pos        <= '0;
                  chipselect <= 1'b1;
                  write      <= 1'b1;
                  address    <= 1'b0;
                  writedata  <= LCD_CMD_CLEAR;
                  tcnt       <= '0;
                  state      <= CLEAR;
               end
            end
            CLEAR, SET_LINE, WRITE_CHR: begin
               if (!waitrequest) begin
                  chipselect <= 1'b0;
                  write      <= 1'b0;
                  if (state == CLEAR) begin
                     state <= GAP;
                  end else if (state == SET_LINE) begin
                     state <= FETCH;
                  end else if (col == LAST_COL) begin
                     col <= '0;
                     if (line == LAST_LINE) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                     end else begin
                        line  <= line + 1'b1;
                        state <= GAP;
                     end
                  end else begin
                     col   <= col + 1'b1;
                     state <= FETCH;
                  end
               end else if (tcnt == LAST_WAIT) begin
                  chipselect <= 1'b0;
                  write      <= 1'b0;
                  error      <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            GAP: begin
               chipselect <= 1'b1;
               write      <= 1'b1;
               address    <= 1'b0;
               writedata  <= LCD_CMD_DDRAM | ((line != '0) ? LINE2_OFFSET : 8'h00);
               tcnt       <= '0;
               state      <= SET_LINE;
            end
            FETCH: begin
               chipselect <= 1'b1;
               write      <= 1'b1;
               address    <= 1'b1;
               writedata  <= rom_q;
               tcnt       <= '0;
               if (pos != LAST_POS) pos <= pos + 1'b1;
               state      <= WRITE_CHR;
            end
            FINISH:  state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_msg_writer.sv
// Bench for lcd_msg_writer: default instance plus a one-line, three-message instance,
// expected write streams queued per run and compared against captured transfers.
module tb_lcd_msg_writer;

   logic       clk = 1'b0;
   logic       reset, start_a, start_b, wrq;
   logic [1:0] sel_a, sel_b;
   logic       busy_a, done_a, err_a, ad_a, cs_a, wr_a;
   logic       busy_b, done_b, err_b, ad_b, cs_b, wr_b;
   logic [7:0] wd_a, wd_b;

   always #5 clk = ~clk;

   lcd_msg_writer dut_a (
      .clk (clk), .reset (reset), .start (start_a), .msg_sel (sel_a),
      .busy (busy_a), .done (done_a), .error (err_a), .address (ad_a),
      .chipselect (cs_a), .write (wr_a), .writedata (wd_a), .waitrequest (wrq)
   );

   lcd_msg_writer #(.NUM_MSG(3), .LINES(1), .MSG_LEN(8), .TIMEOUT(16)) dut_b (
      .clk (clk), .reset (reset), .start (start_b), .msg_sel (sel_b),
      .busy (busy_b), .done (done_b), .error (err_b), .address (ad_b),
      .chipselect (cs_b), .write (wr_b), .writedata (wd_b), .waitrequest (wrq)
   );

   int errors = 0;
   int checks = 0;
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   int         hold_q[$];

   int n_wr, gap_bad, hold_bad, flag_bad, last_held;
   bit got_done, got_err, tmo, aborted;

   function automatic logic [7:0] rom_char(input int idx);
      return 8'(32 + (idx % 95));
   endfunction

   task automatic push_msg(input int m, input int lines, input int len);
      exp_q.push_back({1'b0, 8'h01});
      for (int l = 0; l < lines; l++) begin
         exp_q.push_back({1'b0, (l == 0) ? 8'h80 : 8'hC0});
         for (int c = 0; c < len; c++)
            exp_q.push_back({1'b1, rom_char(m * lines * len + l * len + c)});
      end
   endtask

   task automatic start_run(input bit b, input logic [1:0] m);
      @(negedge clk);
      if (b) begin sel_b = m; start_b = 1'b1; end
      else   begin sel_a = m; start_a = 1'b1; end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Drives waitrequest per transfer and records completed writes; no checking here.
   task automatic run(input bit b, input int stall, input bit stuck_c0,
                      input int abort_at, input int poke_at, input int budget);
      int held = 0;
      int gap = 0;
      bit inx = 0;
      bit poked = 0;
      logic [8:0] first = '0;
      logic [8:0] cur;
      logic c, w, bz, dn, er;
      n_wr = 0; gap_bad = 0; hold_bad = 0; flag_bad = 0; last_held = 0;
      got_done = 0; got_err = 0; tmo = 0; aborted = 0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         if (b) begin c = cs_b; w = wr_b; bz = busy_b; dn = done_b; er = err_b; cur = {ad_b, wd_b}; end
         else   begin c = cs_a; w = wr_a; bz = busy_a; dn = done_a; er = err_a; cur = {ad_a, wd_a}; end
         start_a = 1'b0;
         start_b = 1'b0;
         if (dn) begin got_done = 1; if (bz || er || c) flag_bad++; end
         if (er) begin got_err = 1; if (bz || c || w) flag_bad++; end
         if (dn || er) begin wrq = 1'b0; return; end
         if (c && w) begin
            if (!inx) begin
               inx = 1; held = 0; first = cur;
               if (n_wr > 0 && gap != 1) gap_bad++;
               if (n_wr == abort_at) begin wrq = 1'b1; aborted = 1; return; end
            end else if (cur !== first) begin
               hold_bad++;
            end
            held++;
            last_held = held;
            wrq = stuck_c0 ? (cur == 9'h0C0) : (held <= stall);
            if (!wrq) begin
               obs_q.push_back(cur); hold_q.push_back(held);
               n_wr++; inx = 0; gap = 0;
            end
         end else begin
            wrq = 1'b0;
            gap++;
            if (c || w) flag_bad++;
            if (n_wr == poke_at && !poked) begin
               poked = 1;
               if (b) begin sel_b = 2'd3; start_b = 1'b1; end
               else   begin sel_a = 2'd3; start_a = 1'b1; end
            end
         end
         @(negedge clk);
      end
      tmo = 1;
   endtask

   task automatic test_reset;
      reset = 1'b1; start_a = 1'b1; start_b = 1'b1; sel_a = 2'd1; sel_b = 2'd1;
      repeat (3) @(negedge clk);
      checks++; if ({busy_a, done_a, err_a, cs_a, wr_a, ad_a} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl_a: got %b want 000000", {busy_a, done_a, err_a, cs_a, wr_a, ad_a}); end
      checks++; if (wd_a !== 8'h00) begin errors++; $display("FAIL reset_data_a: got %h want 00", wd_a); end
      checks++; if ({busy_b, done_b, err_b, cs_b, wr_b, ad_b, wd_b} !== 14'b0) begin
         errors++; $display("FAIL reset_b: got %b want 0", {busy_b, done_b, err_b, cs_b, wr_b, ad_b, wd_b}); end
      reset = 1'b0; start_a = 1'b0; start_b = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({busy_a, cs_a, busy_b, cs_b} !== 4'b0) begin
         errors++; $display("FAIL reset_start_ignored: got %b want 0000", {busy_a, cs_a, busy_b, cs_b}); end
   endtask

   task automatic test_basic;
      logic [8:0] e, o;
      push_msg(2, 2, 16);
      start_run(0, 2'd2);
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy_a); end
      run(0, 0, 0, -1, -1, 400);
      checks++; if (tmo || n_wr != 35) begin errors++; $display("FAIL basic_count: got %0d want 35 (tmo=%0d)", n_wr, tmo); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL basic_write: got %h want %h", o, e); end
      end
      obs_q.delete(); hold_q.delete();
      checks++; if (gap_bad != 0 || hold_bad != 0 || flag_bad != 0) begin
         errors++; $display("FAIL basic_protocol: got gap=%0d hold=%0d flag=%0d want 0", gap_bad, hold_bad, flag_bad); end
      checks++; if (!got_done || got_err) begin errors++; $display("FAIL basic_done: got done=%0d err=%0d want 1 0", got_done, got_err); end
      @(negedge clk);
      checks++; if ({done_a, busy_a, cs_a} !== 3'b0) begin
         errors++; $display("FAIL basic_after: got %b want 000", {done_a, busy_a, cs_a}); end
   endtask

   task automatic test_stall;
      logic [8:0] e, o;
      int h;
      push_msg(1, 2, 16);
      start_run(0, 2'd1);
      run(0, 3, 0, -1, -1, 1000);
      checks++; if (tmo || n_wr != 35) begin errors++; $display("FAIL stall_count: got %0d want 35", n_wr); end
      while (hold_q.size() != 0) begin
         h = hold_q.pop_front();
         checks++; if (h != 4) begin errors++; $display("FAIL stall_hold: got %0d want 4", h); end
      end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL stall_write: got %h want %h", o, e); end
      end
      obs_q.delete();
      checks++; if (gap_bad != 0 || hold_bad != 0 || flag_bad != 0 || !got_done) begin
         errors++; $display("FAIL stall_protocol: got gap=%0d hold=%0d flag=%0d done=%0d", gap_bad, hold_bad, flag_bad, got_done); end
   endtask

   task automatic test_timeout;
      logic [8:0] e, o;
      push_msg(0, 2, 16);
      repeat (17) void'(exp_q.pop_back());
      start_run(0, 2'd0);
      run(0, 0, 1, -1, -1, 2000);
      checks++; if (!got_err || got_done || tmo) begin
         errors++; $display("FAIL timeout_error: got err=%0d done=%0d tmo=%0d want 1 0 0", got_err, got_done, tmo); end
      checks++; if (last_held != 1024) begin errors++; $display("FAIL timeout_cycles: got %0d want 1024", last_held); end
      checks++; if (n_wr != 18 || flag_bad != 0) begin
         errors++; $display("FAIL timeout_count: got %0d flag=%0d want 18 0", n_wr, flag_bad); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL timeout_write: got %h want %h", o, e); end
      end
      obs_q.delete(); hold_q.delete();
      @(negedge clk);
      checks++; if ({err_a, busy_a, cs_a, done_a} !== 4'b0) begin
         errors++; $display("FAIL timeout_after: got %b want 0000", {err_a, busy_a, cs_a, done_a}); end
   endtask

   task automatic test_reset_mid;
      logic [8:0] e, o;
      start_run(0, 2'd1);
      run(0, 0, 0, 6, -1, 200);
      checks++; if (!aborted || cs_a !== 1'b1 || ad_a !== 1'b1) begin
         errors++; $display("FAIL midreset_reach: got aborted=%0d cs=%b ad=%b want 1 1 1", aborted, cs_a, ad_a); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if ({busy_a, done_a, err_a, cs_a, wr_a, ad_a, wd_a} !== 14'b0) begin
         errors++; $display("FAIL midreset_outputs: got %b want 0", {busy_a, done_a, err_a, cs_a, wr_a, ad_a, wd_a}); end
      reset = 1'b0; wrq = 1'b0;
      obs_q.delete(); hold_q.delete();
      repeat (2) @(negedge clk);
      checks++; if ({busy_a, cs_a} !== 2'b0) begin errors++; $display("FAIL midreset_idle: got %b want 00", {busy_a, cs_a}); end
      push_msg(1, 2, 16);
      start_run(0, 2'd1);
      run(0, 0, 0, -1, -1, 400);
      checks++; if (tmo || n_wr != 35 || !got_done) begin
         errors++; $display("FAIL midreset_rerun: got %0d done=%0d want 35 1", n_wr, got_done); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL midreset_write: got %h want %h", o, e); end
      end
      obs_q.delete(); hold_q.delete();
   endtask

   task automatic test_busy_start;
      logic [8:0] e, o;
      push_msg(2, 2, 16);
      start_run(0, 2'd2);
      run(0, 0, 0, -1, 5, 400);
      checks++; if (tmo || n_wr != 35 || !got_done) begin
         errors++; $display("FAIL busystart_count: got %0d done=%0d want 35 1", n_wr, got_done); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL busystart_write: got %h want %h", o, e); end
      end
      obs_q.delete(); hold_q.delete();
      repeat (3) @(negedge clk);
      checks++; if ({busy_a, cs_a} !== 2'b0) begin errors++; $display("FAIL busystart_noqueue: got %b want 00", {busy_a, cs_a}); end
      push_msg(3, 2, 16);
      start_run(0, 2'(7));
      run(0, 0, 0, -1, -1, 400);
      checks++; if (tmo || n_wr != 35 || !got_done) begin
         errors++; $display("FAIL busystart_fresh: got %0d done=%0d want 35 1", n_wr, got_done); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL busystart_msg3: got %h want %h", o, e); end
      end
      obs_q.delete(); hold_q.delete();
   endtask

   task automatic test_short_clamp;
      logic [8:0] e, o;
      push_msg(2, 1, 8);
      start_run(1, 2'd3);
      run(1, 0, 0, -1, -1, 100);
      checks++; if (tmo || n_wr != 10 || !got_done || gap_bad != 0 || flag_bad != 0) begin
         errors++; $display("FAIL short_count: got %0d done=%0d gap=%0d flag=%0d want 10 1 0 0", n_wr, got_done, gap_bad, flag_bad); end
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); o = 'x;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL short_write: got %h want %h", o, e); end
      end
      obs_q.delete(); hold_q.delete();
      @(negedge clk);
      checks++; if ({busy_b, done_b, cs_b, busy_a} !== 4'b0) begin
         errors++; $display("FAIL short_after: got %b want 0000", {busy_b, done_b, cs_b, busy_a}); end
   endtask

   initial begin
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
      sel_a = 2'd0; sel_b = 2'd0; wrq = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_timeout();
      test_reset_mid();
      test_busy_start();
      test_short_clamp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
